// File: rtl/ahb_pkg.sv
// AHB-Lite type definitions and burst-engine helpers shared by ahb_burst_master.
// The FSM state list gains ST_ERR only when AHB_ERROR_ABORT_EN is defined.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } HTRANS_E;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } HBURST_E;

  typedef enum logic [2:0] {
    H8    = 3'd0,
    H16   = 3'd1,
    H32   = 3'd2,
    H64   = 3'd3,
    H128  = 3'd4,
    H256  = 3'd5,
    H512  = 3'd6,
    H1024 = 3'd7
  } HSIZE_E;

  localparam int AHB_1KB = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_BURST,
    ST_LAST
`ifdef AHB_ERROR_ABORT_EN
    , ST_ERR
`endif
  } burst_state_e;

  // Undefined-length INCR carries its length as beats-1 in len (up to 16 bits).
  function automatic logic [16:0] burst_beats(HBURST_E burst, logic [15:0] len);
    case (burst)
      INCR:           return {1'b0, len} + 17'd1;
      WRAP4, INCR4:   return 17'd4;
      WRAP8, INCR8:   return 17'd8;
      WRAP16, INCR16: return 17'd16;
      default:        return 17'd1;
    endcase
  endfunction

  function automatic logic is_wrap(HBURST_E burst);
    return (burst == WRAP4) || (burst == WRAP8) || (burst == WRAP16);
  endfunction

endpackage

// File: rtl/ahb_burst_addr_next.sv
// Combinational next-beat address for an AHB burst, plus a flag raised when an
// incrementing burst would step across a 1 KB boundary.
module ahb_burst_addr_next
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  HBURST_E               burst_i,
  input  HSIZE_E                size_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o,
  output logic                  cross_1k_o
);

  localparam logic [ADDR_WIDTH-1:0] KB_MASK = ADDR_WIDTH'(AHB_1KB - 1);

  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] seq_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    incr        = ADDR_WIDTH'(1) << size_i;
    seq_addr    = addr_i + incr;
    wrap_mask   = (ADDR_WIDTH'(burst_beats(burst_i, 16'd0)) << size_i) - ADDR_WIDTH'(1);
    next_addr_o = is_wrap(burst_i) ? ((addr_i & ~wrap_mask) | (seq_addr & wrap_mask))
                                   : seq_addr;
    // Wrapping bursts never leave their own aligned window, so only INCR types can cross.
    cross_1k_o  = !is_wrap(burst_i) && ((seq_addr & ~KB_MASK) != (addr_i & ~KB_MASK));
  end

endmodule

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: one command at a time, NONSEQ/SEQ sequencing with 1 KB
// re-issue. Define AHB_ERROR_ABORT_EN to abort a burst on a two-cycle ERROR response.
module ahb_burst_master
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_burst,
  input  logic [2:0]            req_size,
  input  logic                  req_write,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wdata_pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic [2:0]            HBURST,
  output logic [2:0]            HSIZE,
  output logic                  HWRITE,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  input  logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int         CNT_W    = (LEN_WIDTH > 4) ? LEN_WIDTH : 4;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

  burst_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  HBURST_E               hburst_q, hburst_d;
  HSIZE_E                size_q, size_d;
  logic                  write_q, write_d;
  logic                  nonseq_q, nonseq_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rdata_valid_q, rdata_valid_d;

  HSIZE_E                size_clamped;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  cross_1k;
  logic                  data_phase;
  HTRANS_E               htrans;

`ifdef AHB_ERROR_ABORT_EN
  logic err_q, err_d;
  assign err = err_q;
`else
  logic unused_hresp;
  assign unused_hresp = HRESP;
  assign err          = 1'b0;
`endif

  ahb_burst_addr_next #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_next (
    .addr_i      (addr_q),
    .burst_i     (hburst_q),
    .size_i      (size_q),
    .next_addr_o (next_addr),
    .cross_1k_o  (cross_1k)
  );

  assign size_clamped = (req_size > MAX_SIZE) ? HSIZE_E'(MAX_SIZE) : HSIZE_E'(req_size);
  assign data_phase   = (state_q == ST_BURST) || (state_q == ST_LAST);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d       = state_q;
    addr_d        = addr_q;
    hburst_d      = hburst_q;
    size_d        = size_q;
    write_d       = write_q;
    nonseq_d      = nonseq_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    wdata_pop     = 1'b0;
`ifdef AHB_ERROR_ABORT_EN
    err_d         = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: if (req_valid) begin
        addr_d   = req_addr & ({ADDR_WIDTH{1'b1}} << size_clamped);
        hburst_d = HBURST_E'(req_burst);
        size_d   = size_clamped;
        write_d  = req_write;
        nonseq_d = 1'b0;
        cnt_d    = CNT_W'(burst_beats(HBURST_E'(req_burst), 16'(req_len)) - 17'd1);
        state_d  = ST_ADDR;
      end
      ST_ADDR, ST_BURST: if (HREADY) begin
        if (cnt_q == '0) begin
          state_d = ST_LAST;
        end else begin
          // A 1 KB crossing restarts the transfer as an undefined-length INCR.
          addr_d   = next_addr;
          cnt_d    = cnt_q - CNT_W'(1);
          nonseq_d = cross_1k;
          if (cross_1k) hburst_d = INCR;
          state_d  = ST_BURST;
        end
      end
      ST_LAST: if (HREADY) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
`ifdef AHB_ERROR_ABORT_EN
      ST_ERR: if (HREADY) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        err_d   = 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (data_phase && HREADY) begin
      if (write_q) begin
        wdata_pop = 1'b1;
      end else begin
        rdata_d       = HRDATA;
        rdata_valid_d = 1'b1;
      end
    end

`ifdef AHB_ERROR_ABORT_EN
    // First ERROR cycle: cancel the pending address phase and drop the remaining beats.
    if (data_phase && HRESP && !HREADY) state_d = ST_ERR;
`endif
  end

  always_comb begin
    htrans = IDLE;
    if (state_q == ST_ADDR)       htrans = NONSEQ;
    else if (state_q == ST_BURST) htrans = nonseq_q ? NONSEQ : SEQ;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      hburst_q      <= SINGLE;
      size_q        <= H8;
      write_q       <= 1'b0;
      nonseq_q      <= 1'b0;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
`ifdef AHB_ERROR_ABORT_EN
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      hburst_q      <= hburst_d;
      size_q        <= size_d;
      write_q       <= write_d;
      nonseq_q      <= nonseq_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
`ifdef AHB_ERROR_ABORT_EN
      err_q         <= err_d;
`endif
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign HADDR       = addr_q;
  assign HTRANS      = htrans;
  assign HBURST      = hburst_q;
  assign HSIZE       = size_q;
  assign HWRITE      = write_q;
  assign HWDATA      = wdata;

endmodule

// File: doc/ahb_burst_master.md
# ahb_burst_master

Parametrised AHB-Lite burst master engine: accepts one burst command at a time from a local request interface and drives the full AHB address/data pipeline (NONSEQ/SEQ sequencing, WRAP/INCR address generation, HREADY stalls). It sits between testbench or DMA-style command sources and the AHB interconnect. It is the sequential successor to the bare AHB type definitions, generalised in address/data width and size, and adds 1 KB boundary splitting and optional error abort.

## Interface
- ADDR_WIDTH, 32, HADDR and req_addr width
- DATA_WIDTH, 32, HWDATA/HRDATA width; one of 8/16/32/64/128
- LEN_WIDTH, 8, req_len width (undefined-length INCR beats minus one)
- HCLK  in  1  AHB clock; all logic on the rising edge
- HRESETn  in  1  asynchronous active-low reset
- req_valid  in  1  command valid
- req_ready  out  1  engine idle and able to accept
- req_addr  in  ADDR_WIDTH  start address
- req_burst  in  3  HBURST_E encoding
- req_size  in  3  HSIZE_E encoding
- req_write  in  1  1 = write burst
- req_len  in  LEN_WIDTH  beats-1, used only for INCR
- wdata  in  DATA_WIDTH  write data, driven onto HWDATA combinationally
- wdata_pop  out  1  current write data beat consumed
- rdata  out  DATA_WIDTH  registered HRDATA
- rdata_valid  out  1  rdata holds a completed read beat
- done  out  1  one-cycle pulse at burst completion
- err  out  1  one-cycle pulse with done if burst aborted
- HADDR  out  ADDR_WIDTH; HTRANS out 2; HBURST out 3; HSIZE out 3; HWRITE out 1; HWDATA out DATA_WIDTH
- HREADY  in  1; HRESP  in  1; HRDATA  in  DATA_WIDTH

## Operation
- Reset: HTRANS=IDLE, HADDR=0, HBURST=SINGLE, HSIZE=H8, HWRITE=0, req_ready=1, done/err/rdata_valid/wdata_pop=0, rdata=0.
- FSM: IDLE -> ADDR (NONSEQ) -> BURST (SEQ, overlapped data) -> LAST (final data phase only) -> IDLE; ERR state only with macro.
- Accept on req_valid&&req_ready; req_ready drops next cycle, rises the cycle done pulses.
- Beats: SINGLE=1, INCR=req_len+1, WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16.
- req_size above log2(DATA_WIDTH/8) clamps to that maximum; req_addr low size bits forced to 0.
- Increment = 1<<size. WRAPn: boundary B = beats<<size; next = (addr & ~(B-1)) | ((addr+inc) & (B-1)).
- INCR/INCRn crossing a 1 KB boundary: next beat issued as NONSEQ with HBURST=INCR; beat count unchanged.
- Address phase advances only when HREADY=1; HADDR/HTRANS/HBURST/HSIZE/HWRITE held stable while HREADY=0.
- Data phase completes on HREADY=1: write -> wdata_pop=1; read -> rdata<=HRDATA, rdata_valid=1 for one cycle.
- New req_valid while busy is ignored (req_ready=0).

## Timing
- Cycle 0 accept; cycle 1 first NONSEQ on bus; beat k's data phase is the cycle after its address phase completes.
- Zero-wait N-beat burst: address phases cycles 1..N, data phases 2..N+1, done pulses cycle N+2.
- HREADY low for w cycles extends every phase by w; no bubbles inserted by the engine.
- HRESETn asserted mid-burst: all outputs return to reset values asynchronously; no done pulse.

## Configuration
- AHB_ERROR_ABORT_EN defined: on first ERROR cycle (HRESP=1, HREADY=0) engine drives HTRANS=IDLE next cycle, enters ERR, on second cycle (HRESP=1, HREADY=1) pulses done and err, returns to IDLE; remaining beats dropped.
- Undefined: HRESP ignored, burst runs to completion, err tied 0.

## Structure
- ahb_pkg gains: HTRANS_E/HBURST_E/HSIZE_E (existing), function burst_beats(HBURST_E,len), localparam AHB_1KB=1024, typedef for FSM state enum.
- Sub-module ahb_burst_addr_next: combinational next HADDR and 1 KB-cross flag from addr, burst, size.

## Test plan
- WRAP4 read, addr 0x38, size H32, HREADY=1 -> HADDR 0x38,0x3C,0x30,0x34; NONSEQ,SEQ,SEQ,SEQ; done cycle 6.
- INCR write, req_len=3, addr 0x3F8, size H32 -> 0x3F8,0x3FC (SEQ), 0x400 NONSEQ HBURST=INCR, 0x404 SEQ; 4 wdata_pop.
- INCR8 read, HREADY low 2 cycles at beat 3 -> address/control held stable, rdata_valid 8 times, done cycle 12.
- SINGLE, req_size=H64 with DATA_WIDTH=32 -> HSIZE=H32, addr 0x13 driven as 0x10.
- ERROR on beat 2 of INCR4 (macro on) -> HTRANS=IDLE second error cycle, done+err together, req_ready=1 next; macro off -> all 4 beats, err=0.
- HRESETn low mid-INCR16 -> HTRANS=IDLE, req_ready=1 immediately, no done.
